// File: rtl/mvu_job_sequencer.sv
// APB master that replays CSR-write commands into the MVU array,
// inserting MVU-select writes and tracking per-MVU job completion.
module mvu_job_sequencer #(
  parameter int          N_MVU   = 8,
  parameter logic [11:0] SEL_CSR = 12'h0FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mvu,
  input  logic [11:0]      cmd_csr,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_last,
  output logic [31:0]      paddr,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [31:0]      pwdata,
  input  logic             pready,
  input  logic [N_MVU-1:0] mvu_irq,
  output logic [N_MVU-1:0] mvu_busy,
  output logic [N_MVU-1:0] job_done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEL_SETUP  = 3'd1;
  localparam logic [2:0] S_SEL_ACCESS = 3'd2;
  localparam logic [2:0] S_WR_SETUP   = 3'd3;
  localparam logic [2:0] S_WR_ACCESS  = 3'd4;
  localparam logic [2:0] S_WAIT_FREE  = 3'd5;

  logic [2:0]       state, state_d;
  logic             job_open, sel_valid;
  logic [2:0]       cur_sel;
  logic [N_MVU-1:0] irq_q, rise, busy_d;
  logic             tgt_busy, need_sel, accept;
  logic             bus_d, sel_ph_d, acc_d;

  assign tgt_busy  = mvu_busy[cmd_mvu];
  assign need_sel  = !sel_valid || (cur_sel != cmd_mvu);
  assign accept    = (state == S_WR_ACCESS) && pready;
  assign cmd_ready = accept;
  assign rise      = mvu_irq & ~irq_q;

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!job_open && tgt_busy)
            state_d = S_WAIT_FREE;
          else if (!job_open && need_sel)
            state_d = S_SEL_SETUP;
          else
            state_d = S_WR_SETUP;
        end
      end
      S_WAIT_FREE: begin
        if (!tgt_busy)
          state_d = need_sel ? S_SEL_SETUP : S_WR_SETUP;
      end
      S_SEL_SETUP:  state_d = S_SEL_ACCESS;
      S_SEL_ACCESS: if (pready) state_d = S_WR_SETUP;
      S_WR_SETUP:   state_d = S_WR_ACCESS;
      S_WR_ACCESS:  if (pready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // A cmd_last acceptance wins over a completion clearing the same bit
  always_comb begin
    busy_d = mvu_busy & ~rise;
    if (accept && cmd_last)
      busy_d[cmd_mvu] = 1'b1;
  end

  assign sel_ph_d = (state_d == S_SEL_SETUP) ||
                    (state_d == S_SEL_ACCESS);
  assign acc_d    = (state_d == S_SEL_ACCESS) ||
                    (state_d == S_WR_ACCESS);
  assign bus_d    = sel_ph_d ||
                    (state_d == S_WR_SETUP) ||
                    (state_d == S_WR_ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      job_open  <= 1'b0;
      sel_valid <= 1'b0;
      cur_sel   <= 3'd0;
      irq_q     <= '0;
      mvu_busy  <= '0;
      job_done  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'd0;
      pwdata    <= 32'd0;
    end else begin
      state    <= state_d;
      irq_q    <= mvu_irq;
      mvu_busy <= busy_d;
      job_done <= rise & mvu_busy;
      if (state == S_SEL_ACCESS && pready) begin
        cur_sel   <= cmd_mvu;
        sel_valid <= 1'b1;
      end
      if (accept)
        job_open <= !cmd_last;
      psel    <= bus_d;
      pwrite  <= bus_d;
      penable <= acc_d;
      if (sel_ph_d) begin
        paddr  <= {16'b0, SEL_CSR, 4'b0};
        pwdata <= {29'b0, cmd_mvu};
      end else if (bus_d) begin
        paddr  <= {16'b0, cmd_csr, 4'b0};
        pwdata <= cmd_data;
      end else begin
        paddr  <= 32'd0;
        pwdata <= 32'd0;
      end
    end
  end

endmodule
